audio_sd_sched: RTL and testbench

- Sequences sector reads on the shared SD-card controller and steers each returned byte into either the music sample FIFO or the effect sample FIFO.
- Music is streamed as an endless loop of sectors; effects are one-shot sector runs selected by effect_in.
- Sits between sd_controller (read side only) and the two sample FIFOs that feed audio_pwm and the mixer.
- All SD handshake signals are synchronous to clk_100mhz; clock bridging is done outside this block.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_sector_arb.sv | 62 ++++++
 rtl/audio_sd_sched.sv | 198 +++++++++++++++++++
 tb/tb_audio_sd_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the SD sector scheduler that feeds the audio sample FIFOs.
package audio_pkg;

   typedef logic [7:0] sample_t;

   localparam int SECTOR_BYTES = 512;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      XFER
   } state_t;

   typedef enum logic {
      DST_MUSIC,
      DST_EFFECT
   } dst_t;

   // A sector index becomes a byte address by appending the 9 in-sector offset bits.
   function automatic logic [31:0] sector_to_addr(input logic [22:0] sector);
      return {sector, 9'b0};
   endfunction

endpackage

// File: rtl/audio_sector_arb.sv
// Picks the next sector to read: effect first when its FIFO has room for a whole sector,
// otherwise music, and forms the SD byte address of the chosen sector.
module audio_sector_arb
   import audio_pkg::*;
#(
   parameter int MUSIC_START_SECTOR = 0,
   parameter int EFFECT_BASE_SECTOR = 4096,
   parameter int EFFECT_SECTORS     = 64,
   parameter int FIFO_DEPTH         = 1024,
   parameter int CNT_W              = 11
)(
   input  logic             effect_active,
   input  logic [1:0]       effect_sel,
   input  logic [22:0]      effect_ptr,
   input  logic [22:0]      music_ptr,
   input  logic [CNT_W-1:0] music_count,
   input  logic [CNT_W-1:0] effect_count,
   output logic             choose,
   output logic             dst_is_effect,
   output logic [31:0]      addr
);

   localparam logic [22:0] MUSIC_BASE  = 23'(MUSIC_START_SECTOR);
   localparam logic [22:0] EFFECT_BASE = 23'(EFFECT_BASE_SECTOR);
   localparam logic [22:0] EFFECT_SPAN = 23'(EFFECT_SECTORS);

   logic [CNT_W-1:0] count_arr [2];
   logic [1:0]       has_space;
   logic [22:0]      effect_slot;
   logic [22:0]      effect_sector;
   logic [22:0]      music_sector;
   logic [22:0]      chosen_sector;

   assign count_arr[0] = music_count;
   assign count_arr[1] = effect_count;

   // Free space >= one sector, rewritten as count + 512 <= depth so it cannot underflow.
   for (genvar gi = 0; gi < 2; gi++) begin : g_space
      assign has_space[gi] = (32'(count_arr[gi]) + 32'(SECTOR_BYTES)) <= 32'(FIFO_DEPTH);
   end

   assign effect_slot   = 23'(effect_sel) - 23'd1;
   assign effect_sector = EFFECT_BASE + effect_slot * EFFECT_SPAN + effect_ptr;
   assign music_sector  = MUSIC_BASE + music_ptr;

   always_comb begin
      choose        = 1'b0;
      dst_is_effect = 1'b0;
      chosen_sector = music_sector;
      if (effect_active && has_space[1]) begin
         choose        = 1'b1;
         dst_is_effect = 1'b1;
         chosen_sector = effect_sector;
      end else if (has_space[0]) begin
         choose        = 1'b1;
         chosen_sector = music_sector;
      end
   end

   assign addr = sector_to_addr(chosen_sector);

endmodule

// File: rtl/audio_sd_sched.sv
// Sequences SD sector reads for the endless music loop and one-shot effects, and steers
// each returned byte into the music or effect sample FIFO.
module audio_sd_sched
   import audio_pkg::*;
#(
   parameter int MUSIC_START_SECTOR = 0,
   parameter int MUSIC_SECTORS      = 2048,
   parameter int EFFECT_BASE_SECTOR = 4096,
   parameter int EFFECT_SECTORS     = 64,
   parameter int FIFO_DEPTH         = 1024,
   parameter int CNT_W              = 11
)(
   input  logic             clk_100mhz,
   input  logic             rst_n_in,
   input  logic [1:0]       effect_in,
   input  logic             sd_ready_in,
   output logic             sd_rd_out,
   output logic [31:0]      sd_addr_out,
   input  logic [7:0]       sd_byte_in,
   input  logic             sd_byte_valid_in,
   input  logic [CNT_W-1:0] music_count_in,
   input  logic [CNT_W-1:0] effect_count_in,
   output logic             music_wr_out,
   output logic             effect_wr_out,
   output logic [7:0]       wr_data_out,
   output logic             effect_active_out,
   output logic             effect_done_out,
   output logic             error_out
);

   localparam logic [22:0] MUSIC_LAST  = 23'(MUSIC_SECTORS - 1);
   localparam logic [22:0] EFFECT_LAST = 23'(EFFECT_SECTORS - 1);
   localparam logic [9:0]  FULL_COUNT  = 10'(SECTOR_BYTES);

   state_t      state_reg, state_next;
   dst_t        dst_reg, dst_next;
   logic [22:0] music_ptr_reg, music_ptr_next;
   logic [22:0] effect_ptr_reg, effect_ptr_next;
   logic [1:0]  effect_sel_reg, effect_sel_next;
   logic        effect_active_reg, effect_active_next;
   logic [9:0]  byte_cnt_reg, byte_cnt_next;
   logic [31:0] addr_reg, addr_next;
   logic        music_wr_reg, music_wr_next;
   logic        effect_wr_reg, effect_wr_next;
   sample_t     data_reg, data_next;
   logic        done_reg, done_next;
   logic        error_reg, error_next;

   logic        latch_now;
   logic        arb_active;
   logic [1:0]  arb_sel;
   logic [22:0] arb_effect_ptr;
   logic        arb_choose;
   logic        arb_dst_effect;
   logic [31:0] arb_addr;
   logic        byte_accept;
   logic [9:0]  cnt_after;

   // The arbiter must see an effect latched in this same IDLE cycle, starting at sector 0.
   assign latch_now      = (state_reg == IDLE) && sd_ready_in && !effect_active_reg
                           && (effect_in != 2'd0);
   assign arb_active     = effect_active_reg | latch_now;
   assign arb_sel        = latch_now ? effect_in : effect_sel_reg;
   assign arb_effect_ptr = latch_now ? 23'd0 : effect_ptr_reg;

   audio_sector_arb #(
      .MUSIC_START_SECTOR (MUSIC_START_SECTOR),
      .EFFECT_BASE_SECTOR (EFFECT_BASE_SECTOR),
      .EFFECT_SECTORS     (EFFECT_SECTORS),
      .FIFO_DEPTH         (FIFO_DEPTH),
      .CNT_W              (CNT_W)
   ) u_arb (
      .effect_active (arb_active),
      .effect_sel    (arb_sel),
      .effect_ptr    (arb_effect_ptr),
      .music_ptr     (music_ptr_reg),
      .music_count   (music_count_in),
      .effect_count  (effect_count_in),
      .choose        (arb_choose),
      .dst_is_effect (arb_dst_effect),
      .addr          (arb_addr)
   );

   assign byte_accept = (state_reg == XFER) && sd_byte_valid_in && (byte_cnt_reg != FULL_COUNT);
   assign cnt_after   = byte_cnt_reg + {9'd0, byte_accept};

   always_comb begin
      state_next         = state_reg;
      dst_next           = dst_reg;
      music_ptr_next     = music_ptr_reg;
      effect_ptr_next    = effect_ptr_reg;
      effect_sel_next    = effect_sel_reg;
      effect_active_next = effect_active_reg;
      byte_cnt_next      = byte_cnt_reg;
      addr_next          = addr_reg;
      music_wr_next      = 1'b0;
      effect_wr_next     = 1'b0;
      data_next          = data_reg;
      done_next          = 1'b0;
      error_next         = error_reg;

      // Strays outside XFER and bytes beyond a full sector are dropped and flagged.
      if (sd_byte_valid_in && !byte_accept) begin
         error_next = 1'b1;
      end
      if (byte_accept) begin
         music_wr_next  = (dst_reg == DST_MUSIC);
         effect_wr_next = (dst_reg == DST_EFFECT);
         data_next      = sd_byte_in;
         byte_cnt_next  = cnt_after;
      end

      case (state_reg)
         IDLE: begin
            if (sd_ready_in) begin
               if (latch_now) begin
                  effect_active_next = 1'b1;
                  effect_sel_next    = effect_in;
                  effect_ptr_next    = 23'd0;
               end
               if (arb_choose) begin
                  addr_next  = arb_addr;
                  dst_next   = arb_dst_effect ? DST_EFFECT : DST_MUSIC;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!sd_ready_in) begin
               byte_cnt_next = 10'd0;
               state_next    = XFER;
            end
         end
         XFER: begin
            if (sd_ready_in) begin
               if (cnt_after != FULL_COUNT) begin
                  error_next = 1'b1;
               end
               if (dst_reg == DST_EFFECT) begin
                  if (effect_ptr_reg == EFFECT_LAST) begin
                     effect_ptr_next    = 23'd0;
                     effect_active_next = 1'b0;
                     done_next          = 1'b1;
                  end else begin
                     effect_ptr_next = effect_ptr_reg + 23'd1;
                  end
               end else begin
                  music_ptr_next = (music_ptr_reg == MUSIC_LAST) ? 23'd0 : music_ptr_reg + 23'd1;
               end
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg         <= IDLE;
         dst_reg           <= DST_MUSIC;
         music_ptr_reg     <= 23'd0;
         effect_ptr_reg    <= 23'd0;
         effect_sel_reg    <= 2'd0;
         effect_active_reg <= 1'b0;
         byte_cnt_reg      <= 10'd0;
         addr_reg          <= 32'd0;
         music_wr_reg      <= 1'b0;
         effect_wr_reg     <= 1'b0;
         data_reg          <= 8'd0;
         done_reg          <= 1'b0;
         error_reg         <= 1'b0;
      end else begin
         state_reg         <= state_next;
         dst_reg           <= dst_next;
         music_ptr_reg     <= music_ptr_next;
         effect_ptr_reg    <= effect_ptr_next;
         effect_sel_reg    <= effect_sel_next;
         effect_active_reg <= effect_active_next;
         byte_cnt_reg      <= byte_cnt_next;
         addr_reg          <= addr_next;
         music_wr_reg      <= music_wr_next;
         effect_wr_reg     <= effect_wr_next;
         data_reg          <= data_next;
         done_reg          <= done_next;
         error_reg         <= error_next;
      end
   end

   assign sd_rd_out         = (state_reg == ISSUE);
   assign sd_addr_out       = addr_reg;
   assign music_wr_out      = music_wr_reg;
   assign effect_wr_out     = effect_wr_reg;
   assign wr_data_out       = data_reg;
   assign effect_active_out = effect_active_reg;
   assign effect_done_out   = done_reg;
   assign error_out         = error_reg;

endmodule

// File: tb/tb_audio_sd_sched.sv
// Directed-plus-random bench for audio_sd_sched: acts as the SD controller and checks
// addresses, FIFO steering and flags against a sector-level reference model.
module tb_audio_sd_sched;

   localparam int MUS_START = 0;
   localparam int MUS_N     = 3;
   localparam int EFX_BASE  = 4096;
   localparam int EFX_N     = 4;
   localparam int DEPTH     = 1024;

   logic        clk_100mhz = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [1:0]  effect_in = 2'd0;
   logic        sd_ready_in = 1'b0;
   logic        sd_rd_out;
   logic [31:0] sd_addr_out;
   logic [7:0]  sd_byte_in = 8'd0;
   logic        sd_byte_valid_in = 1'b0;
   logic [10:0] music_count_in = 11'd0;
   logic [10:0] effect_count_in = 11'd0;
   logic        music_wr_out;
   logic        effect_wr_out;
   logic [7:0]  wr_data_out;
   logic        effect_active_out;
   logic        effect_done_out;
   logic        error_out;

   always #5 clk_100mhz = ~clk_100mhz;

   audio_sd_sched #(
      .MUSIC_START_SECTOR (MUS_START),
      .MUSIC_SECTORS      (MUS_N),
      .EFFECT_BASE_SECTOR (EFX_BASE),
      .EFFECT_SECTORS     (EFX_N),
      .FIFO_DEPTH         (DEPTH),
      .CNT_W              (11)
   ) dut (
      .clk_100mhz        (clk_100mhz),
      .rst_n_in          (rst_n_in),
      .effect_in         (effect_in),
      .sd_ready_in       (sd_ready_in),
      .sd_rd_out         (sd_rd_out),
      .sd_addr_out       (sd_addr_out),
      .sd_byte_in        (sd_byte_in),
      .sd_byte_valid_in  (sd_byte_valid_in),
      .music_count_in    (music_count_in),
      .effect_count_in   (effect_count_in),
      .music_wr_out      (music_wr_out),
      .effect_wr_out     (effect_wr_out),
      .wr_data_out       (wr_data_out),
      .effect_active_out (effect_active_out),
      .effect_done_out   (effect_done_out),
      .error_out         (error_out)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: sector pointers and flags, advanced once per completed sector.
   int m_music_ptr;
   int m_eff_ptr;
   int m_eff_sel;
   bit m_eff_active;
   bit m_error;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic void model_reset();
      m_music_ptr  = 0;
      m_eff_ptr    = 0;
      m_eff_sel    = 0;
      m_eff_active = 0;
      m_error      = 0;
   endfunction

   function automatic bit model_pick(input int eff_req, input int mcount, input int ecount,
                                     output logic [31:0] addr, output bit to_eff);
      if (!m_eff_active && eff_req != 0) begin
         m_eff_active = 1;
         m_eff_sel    = eff_req;
         m_eff_ptr    = 0;
      end
      to_eff = 0;
      addr   = 32'd0;
      if (m_eff_active && (DEPTH - ecount) >= 512) begin
         to_eff = 1;
         addr   = 32'((EFX_BASE + (m_eff_sel - 1) * EFX_N + m_eff_ptr) * 512);
         return 1;
      end
      if ((DEPTH - mcount) >= 512) begin
         addr = 32'((MUS_START + m_music_ptr) * 512);
         return 1;
      end
      return 0;
   endfunction

   function automatic bit model_finish(input bit to_eff, input int nbytes);
      if (nbytes != 512) m_error = 1;
      if (to_eff) begin
         m_eff_ptr++;
         if (m_eff_ptr == EFX_N) begin
            m_eff_ptr    = 0;
            m_eff_active = 0;
            return 1;
         end
      end else begin
         m_music_ptr = (m_music_ptr + 1) % MUS_N;
      end
      return 0;
   endfunction

   // One SD read: wait for the request, stream nbytes with random gaps, then complete.
   // rst_at > 0 asserts reset right after that many bytes have been taken.
   task automatic run_sector(input int nbytes, input int rst_at);
      logic [31:0] exp_addr;
      bit          to_eff;
      bit          picked;
      bit          exp_done;
      bit          exp_m;
      bit          exp_e;
      logic [7:0]  exp_d;
      logic [7:0]  d;
      int          w;
      int          i;
      picked = model_pick(int'(effect_in), int'(music_count_in), int'(effect_count_in),
                          exp_addr, to_eff);
      sd_ready_in = 1'b1;
      w = 0;
      while (sd_rd_out !== 1'b1 && w < 2) begin
         @(negedge clk_100mhz);
         w++;
      end
      check("rd_issue", {63'd0, sd_rd_out}, {63'd0, picked});
      check("addr", {32'd0, sd_addr_out}, {32'd0, exp_addr});
      check("active", {63'd0, effect_active_out}, {63'd0, m_eff_active});
      $display("sector addr=%08h dst=%s bytes=%0d", sd_addr_out, to_eff ? "effect" : "music", nbytes);
      sd_ready_in = 1'b0;
      @(negedge clk_100mhz);
      i = 0;
      while (i < nbytes) begin
         exp_m = 0;
         exp_e = 0;
         exp_d = 8'd0;
         if ($urandom_range(0, 3) != 0) begin
            d = 8'($urandom);
            sd_byte_valid_in = 1'b1;
            sd_byte_in = d;
            if (i < 512) begin
               exp_m = !to_eff;
               exp_e = to_eff;
               exp_d = d;
            end
            i++;
         end else begin
            sd_byte_valid_in = 1'b0;
         end
         if (i == rst_at) begin
            @(posedge clk_100mhz);
            #2;
            rst_n_in = 1'b0;
            #1;
            check("reset_mid_xfer", {18'd0, sd_rd_out, sd_addr_out, music_wr_out, effect_wr_out,
                  wr_data_out, effect_active_out, effect_done_out, error_out}, 64'd0);
            sd_byte_valid_in = 1'b0;
            sd_ready_in = 1'b0;
            model_reset();
            @(negedge clk_100mhz);
            rst_n_in = 1'b1;
            @(negedge clk_100mhz);
            return;
         end
         @(negedge clk_100mhz);
         check("strobe", {62'd0, music_wr_out, effect_wr_out}, {62'd0, exp_m, exp_e});
         if (exp_m || exp_e) check("data", {56'd0, wr_data_out}, {56'd0, exp_d});
      end
      sd_byte_valid_in = 1'b0;
      sd_ready_in = 1'b1;
      exp_done = model_finish(to_eff, nbytes);
      @(negedge clk_100mhz);
      sd_ready_in = 1'b0;
      check("done", {63'd0, effect_done_out}, {63'd0, exp_done});
      check("active_end", {63'd0, effect_active_out}, {63'd0, m_eff_active});
      check("error", {63'd0, error_out}, {63'd0, m_error});
      check("strobe_end", {62'd0, music_wr_out, effect_wr_out}, 64'd0);
      @(negedge clk_100mhz);
      check("done_pulse_width", {63'd0, effect_done_out}, 64'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk_100mhz);
      check("reset_outputs", {18'd0, sd_rd_out, sd_addr_out, music_wr_out, effect_wr_out,
            wr_data_out, effect_active_out, effect_done_out, error_out}, 64'd0);
      rst_n_in = 1'b1;
      @(negedge clk_100mhz);

      // Music only; the fourth sector wraps to address 0.
      effect_in = 2'd0;
      effect_count_in = 11'd0;
      for (int k = 0; k < 4; k++) begin
         music_count_in = 11'($urandom_range(0, 512));
         run_sector(512, -1);
      end

      // Music backpressure: 424 bytes free is not enough for a sector.
      music_count_in = 11'd600;
      sd_ready_in = 1'b1;
      repeat (20) begin
         @(negedge clk_100mhz);
         check("bp_no_rd", {63'd0, sd_rd_out}, 64'd0);
      end
      music_count_in = 11'd512;
      run_sector(512, -1);

      // Effect 2 takes priority, then random requests and FIFO levels.
      for (int k = 0; k < 14; k++) begin
         effect_in = (k == 0) ? 2'd2 : 2'($urandom_range(0, 3));
         music_count_in = 11'($urandom_range(0, 512));
         if (k == 0 || $urandom_range(0, 3) != 0)
            effect_count_in = 11'($urandom_range(0, 512));
         else
            effect_count_in = 11'($urandom_range(513, 1024));
         run_sector(512, -1);
      end

      // Short sector, then an over-long one, then a normal one; error stays set.
      effect_in = 2'd0;
      effect_count_in = 11'd0;
      music_count_in = 11'd0;
      run_sector(100, -1);
      run_sector(513, -1);
      run_sector(512, -1);

      // Reset during byte 200, then the first read starts the music loop again.
      run_sector(512, 200);
      run_sector(512, -1);

      // A byte strobe while idle is dropped and flagged.
      sd_byte_valid_in = 1'b1;
      sd_byte_in = 8'hA5;
      @(negedge clk_100mhz);
      sd_byte_valid_in = 1'b0;
      check("stray_strobe", {62'd0, music_wr_out, effect_wr_out}, 64'd0);
      check("stray_error", {63'd0, error_out}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
